// File: rtl/nibble_max_pkg.sv
// Shared sizing helpers and default geometry for the nibble max selector.
// Pure constants and constant functions; no logic, no latency.
// Not applicable: no flow control in a package.
package nibble_max_pkg;

    localparam int LANE_W_DEF    = 4;
    localparam int NUM_LANES_DEF = 8;
    localparam int NUM_PICKS_DEF = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single pick still needs a one-bit index port.
    function automatic int pick_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    localparam int IDX_W_DEF  = clog2(NUM_LANES_DEF);
    localparam int PICK_W_DEF = pick_w(NUM_PICKS_DEF);

endpackage

// File: rtl/nibble_lane_mux.sv
// Extracts one lane from a packed word; out-of-range index yields zero.
// Latency: combinational.
// Backpressure: none, pure datapath.
module nibble_lane_mux #(
    parameter int LANE_W    = 4,
    parameter int NUM_LANES = 8,
    parameter int IDX_W     = 3
) (
    input  logic [NUM_LANES*LANE_W-1:0] word,
    input  logic [IDX_W-1:0]            idx,
    output logic [LANE_W-1:0]           lane
);

    always_comb begin
        lane = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (idx == IDX_W'(i)) begin
                lane = word[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/nibble_max_pipe.sv
// Picks NUM_PICKS lanes from A/B per beat and registers the max and its pick (NIBBLE_MAX_FRAME_ACC_EN: per-frame max).
// Latency: two register stages (candidates, then result).
// Backpressure: global stall, both stages advance only when !out_valid || out_ready.
module nibble_max_pipe
    import nibble_max_pkg::*;
#(
    parameter int LANE_W    = LANE_W_DEF,
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int NUM_PICKS = NUM_PICKS_DEF,
    localparam int IDX_W    = clog2(NUM_LANES),
    localparam int PICK_W   = pick_w(NUM_PICKS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [NUM_LANES*LANE_W-1:0] data_a,
    input  logic [NUM_LANES*LANE_W-1:0] data_b,
    input  logic [NUM_PICKS*IDX_W-1:0]  sel_a,
    input  logic [NUM_PICKS*IDX_W-1:0]  sel_b,
    input  logic [NUM_PICKS-1:0]        sel_ab,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANE_W-1:0]           data_out,
    output logic [PICK_W-1:0]           pick_out
);

    logic                en;
    logic [LANE_W-1:0]   lane_a  [NUM_PICKS];
    logic [LANE_W-1:0]   lane_b  [NUM_PICKS];
    logic [LANE_W-1:0]   cand_d  [NUM_PICKS];
    logic [LANE_W-1:0]   cand_q  [NUM_PICKS];
    logic                s1_vld;
    logic [LANE_W-1:0]   best_val;
    logic [PICK_W-1:0]   best_pick;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar p = 0; p < NUM_PICKS; p++) begin : g_pick
        nibble_lane_mux #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_mux_a (
            .word (data_a),
            .idx  (sel_a[p*IDX_W +: IDX_W]),
            .lane (lane_a[p])
        );
        nibble_lane_mux #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_mux_b (
            .word (data_b),
            .idx  (sel_b[p*IDX_W +: IDX_W]),
            .lane (lane_b[p])
        );
        assign cand_d[p] = sel_ab[p] ? lane_b[p] : lane_a[p];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            for (int p = 0; p < NUM_PICKS; p++) begin
                cand_q[p] <= '0;
            end
        end else if (en) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                cand_q <= cand_d;
            end
        end
    end

    // Strict compare keeps the lowest pick index on ties.
    always_comb begin
        best_val  = cand_q[0];
        best_pick = '0;
        for (int p = 1; p < NUM_PICKS; p++) begin
            if (cand_q[p] > best_val) begin
                best_val  = cand_q[p];
                best_pick = PICK_W'(p);
            end
        end
    end

`ifdef NIBBLE_MAX_FRAME_ACC_EN
    logic              s1_last;
    logic              acc_vld;
    logic [LANE_W-1:0] acc_val;
    logic [PICK_W-1:0] acc_pick;
    logic              take_new;
    logic [LANE_W-1:0] mrg_val;
    logic [PICK_W-1:0] mrg_pick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_last <= 1'b0;
        end else if (en) begin
            s1_last <= in_last;
        end
    end

    // First beat of a frame always loads; later beats must be strictly greater.
    always_comb begin
        take_new = !acc_vld || (best_val > acc_val);
        mrg_val  = take_new ? best_val  : acc_val;
        mrg_pick = take_new ? best_pick : acc_pick;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            pick_out  <= '0;
            acc_vld   <= 1'b0;
            acc_val   <= '0;
            acc_pick  <= '0;
        end else if (en) begin
            out_valid <= s1_vld && s1_last;
            if (s1_vld) begin
                if (s1_last) begin
                    data_out <= mrg_val;
                    pick_out <= mrg_pick;
                    acc_vld  <= 1'b0;
                    acc_val  <= '0;
                    acc_pick <= '0;
                end else begin
                    acc_vld  <= 1'b1;
                    acc_val  <= mrg_val;
                    acc_pick <= mrg_pick;
                end
            end
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            pick_out  <= '0;
        end else if (en) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                data_out <= best_val;
                pick_out <= best_pick;
            end
        end
    end
`endif

endmodule
